// File: rtl/dbf_line_seq_pkg.sv
// dbf_line_seq_pkg: shared sizes, state encoding, config struct and helpers
// for the DBF per-line receive sequencer.
// Ports: none (package).
package dbf_line_seq_pkg;

   localparam int ADDR_WD   = 10;   // LUT address width, 2^ADDR_WD >= NUM_LINES*NUM_ZONES
   localparam int NUM_LINES = 64;   // lines per frame, power of 2
   localparam int NUM_ZONES = 16;   // focal zones per line, power of 2
   localparam int ZONE_LEN  = 64;   // receive cycles per focal zone
   localparam int LEN_WD    = 8;    // tx / dead length config width
   localparam int RX_WD     = 14;   // receive length config width

   // Constant ceil(log2(value)); used only for elaboration-time sizing.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int LINE_WD = clog2(NUM_LINES);
   localparam int ZONE_WD = clog2(NUM_ZONES);
   localparam int ZCNT_WD = clog2(ZONE_LEN);
   localparam int CNT_WD  = (RX_WD > LEN_WD) ? RX_WD : LEN_WD;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_TX   = 3'd1;
   localparam logic [2:0] ST_DEAD = 3'd2;
   localparam logic [2:0] ST_RX   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_TX   = ST_TX,
      S_DEAD = ST_DEAD,
      S_RX   = ST_RX,
      S_DONE = ST_DONE
   } state_t;

   // Per-line timing configuration, captured when a trigger is accepted.
   typedef struct packed {
      logic [LEN_WD-1:0] tx_len;
      logic [LEN_WD-1:0] dead_len;
      logic [RX_WD-1:0]  rx_len;
   } cfg_t;

   // Delay LUT address {line, zone}, zero-extended to ADDR_WD.
   function automatic logic [ADDR_WD-1:0] lut_addr(input logic [LINE_WD-1:0] line,
                                                   input logic [ZONE_WD-1:0] zone);
      logic [ADDR_WD-1:0] a;
      a = '0;
      a[ZONE_WD +: LINE_WD] = line;
      a[ZONE_WD-1:0]        = zone;
      return a;
   endfunction

endpackage

// File: rtl/dbf_line_seq_if.sv
// dbf_line_seq_if: trigger/config inputs and line/LUT outputs of the sequencer.
// Ports: master = sequencer side (drives tx_en, start, LUT strobe, status),
//        slave  = controller / channel-bank side (drives trig, frame_start, cfg_*).
// Purpose: bundle for one sequencer instance and its shared fan-out.
// Latency: n/a (wires only).
// Backpressure: none; all signals are pulses or levels.
interface dbf_line_seq_if;
   import dbf_line_seq_pkg::*;

   logic               trig;
   logic               frame_start;
   logic [LEN_WD-1:0]  cfg_tx_len;
   logic [LEN_WD-1:0]  cfg_dead_len;
   logic [RX_WD-1:0]   cfg_rx_len;

   logic               tx_en;
   logic               start;
   logic [ADDR_WD-1:0] dbf_lut_addr;
   logic               dbf_lut_we;
   logic [LINE_WD-1:0] line_idx;
   logic               busy;
   logic               line_done;
   logic               frame_done;
   logic               trig_err;

   modport master (
      input  trig, frame_start, cfg_tx_len, cfg_dead_len, cfg_rx_len,
      output tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx,
             busy, line_done, frame_done, trig_err
   );

   modport slave (
      output trig, frame_start, cfg_tx_len, cfg_dead_len, cfg_rx_len,
      input  tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx,
             busy, line_done, frame_done, trig_err
   );

endinterface

// File: rtl/dbf_line_seq_zone_ctr.sv
// dbf_zone_ctr: focal-zone stepper for the receive window.
// Ports: clk, rst (sync, active-high); load = first RX cycle next, en = RX continues,
//        line = current line index; we = one-cycle LUT strobe, addr = held LUT address.
// Purpose: zone index / LUT read strobe generation, one strobe per ZONE_LEN cycles.
// Latency: we/addr registered, valid the cycle after load/en is sampled.
// Backpressure: none; saturates at the last zone and stops strobing.
module dbf_zone_ctr
   import dbf_line_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               en,
   input  logic [LINE_WD-1:0] line,
   output logic               we,
   output logic [ADDR_WD-1:0] addr
);

   localparam logic [ZONE_WD-1:0] ZONE_LAST = ZONE_WD'(NUM_ZONES - 1);
   localparam logic [ZCNT_WD-1:0] ZCNT_LOAD = ZCNT_WD'(ZONE_LEN - 1);

   logic [ZCNT_WD-1:0] zcnt;
   logic [ZONE_WD-1:0] zone;

   always_ff @(posedge clk) begin
      if (rst) begin
         zcnt <= '0;
         zone <= '0;
         we   <= 1'b0;
         addr <= '0;
      end else begin
         we <= 1'b0;
         if (load) begin
            zcnt <= ZCNT_LOAD;
            zone <= '0;
            we   <= 1'b1;
            addr <= lut_addr(line, '0);
         end else if (en) begin
            if (zcnt != '0) begin
               zcnt <= zcnt - ZCNT_WD'(1);
            end else if (zone != ZONE_LAST) begin
               // Zone boundary: advance and strobe; the address moves with the strobe.
               zcnt <= ZCNT_LOAD;
               zone <= zone + ZONE_WD'(1);
               we   <= 1'b1;
               addr <= lut_addr(line, zone + ZONE_WD'(1));
            end
         end
      end
   end

endmodule

// File: rtl/dbf_line_seq.sv
// dbf_line_seq: per-line transmit / dead-time / receive-window sequencer.
// Ports: clk, rst (sync, active-high); bus (dbf_line_seq_if.master): trig, frame_start,
//        cfg_* in; tx_en, start, dbf_lut_addr/we, line_idx, busy, line_done, frame_done, trig_err out.
// Purpose: IDLE->TX->DEAD->RX->DONE per trigger, zero-length phases skipped.
// Latency: all outputs registered; tx_en rises one cycle after the accepted trig.
// Backpressure: trig while busy is dropped and flagged on trig_err one cycle later.
module dbf_line_seq
   import dbf_line_seq_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   dbf_line_seq_if.master bus
);

   state_t             state, state_nxt;
   logic [CNT_WD-1:0]  cnt, cnt_nxt;
   cfg_t               cfg_in, cfg_q, cfg_use;
   logic               pend;
   logic               pend_eff;
   logic [LINE_WD-1:0] line_q, line_cur;
   logic               done_entry, rx_load, rx_hold;

   logic               tx_en_q, start_q, busy_q, line_done_q, frame_done_q, trig_err_q;
   logic               lut_we;
   logic [ADDR_WD-1:0] lut_addr_q;

   assign cfg_in = {bus.cfg_tx_len, bus.cfg_dead_len, bus.cfg_rx_len};

   // First phase at or after 's' whose length is non-zero; skips cost no cycles.
   function automatic state_t skip_zero(input state_t s, input cfg_t c);
      state_t r;
      r = s;
      if (r == S_TX   && c.tx_len   == '0) r = S_DEAD;
      if (r == S_DEAD && c.dead_len == '0) r = S_RX;
      if (r == S_RX   && c.rx_len   == '0) r = S_DONE;
      return r;
   endfunction

   function automatic logic [CNT_WD-1:0] load_val(input state_t s, input cfg_t c);
      logic [CNT_WD-1:0] v;
      case (s)
         S_TX:    v = CNT_WD'(c.tx_len)   - CNT_WD'(1);
         S_DEAD:  v = CNT_WD'(c.dead_len) - CNT_WD'(1);
         S_RX:    v = CNT_WD'(c.rx_len)   - CNT_WD'(1);
         default: v = '0;
      endcase
      return v;
   endfunction

   // In IDLE the live config is used so the accepting cycle already sees it.
   assign cfg_use = (state == S_IDLE) ? cfg_in : cfg_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: if (bus.trig) state_nxt = skip_zero(S_TX, cfg_use);
         S_TX:   if (cnt == '0) state_nxt = skip_zero(S_DEAD, cfg_use);
                 else cnt_nxt = cnt - CNT_WD'(1);
         S_DEAD: if (cnt == '0) state_nxt = skip_zero(S_RX, cfg_use);
                 else cnt_nxt = cnt - CNT_WD'(1);
         S_RX:   if (cnt == '0) state_nxt = S_DONE;
                 else cnt_nxt = cnt - CNT_WD'(1);
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = load_val(state_nxt, cfg_use);
   end

   // A frame_start in IDLE takes effect at once, including for a line fired in the same cycle.
   assign line_cur   = (state == S_IDLE && bus.frame_start) ? '0 : line_q;
   assign pend_eff   = pend | (bus.frame_start && state != S_IDLE);
   assign done_entry = (state_nxt == S_DONE) && (state != S_DONE);
   assign rx_load    = (state_nxt == S_RX) && (state != S_RX);
   assign rx_hold    = (state_nxt == S_RX) && (state == S_RX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cfg_q        <= '0;
         pend         <= 1'b0;
         line_q       <= '0;
         tx_en_q      <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         trig_err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_IDLE && bus.trig) cfg_q <= cfg_in;

         // A frame restart requested mid-line replaces the DONE increment.
         if (done_entry) begin
            pend   <= 1'b0;
            line_q <= pend_eff ? '0 : line_cur + LINE_WD'(1);
         end else begin
            if (bus.frame_start && state != S_IDLE) pend <= 1'b1;
            if (bus.frame_start && state == S_IDLE) line_q <= '0;
         end

         tx_en_q      <= (state_nxt == S_TX);
         start_q      <= (state_nxt == S_RX);
         busy_q       <= (state_nxt != S_IDLE);
         line_done_q  <= done_entry;
         frame_done_q <= done_entry && (line_cur == LINE_WD'(NUM_LINES - 1));
         trig_err_q   <= bus.trig && (state != S_IDLE);
      end
   end

   dbf_zone_ctr u_zone (
      .clk  (clk),
      .rst  (rst),
      .load (rx_load),
      .en   (rx_hold),
      .line (line_cur),
      .we   (lut_we),
      .addr (lut_addr_q)
   );

   assign bus.tx_en        = tx_en_q;
   assign bus.start        = start_q;
   assign bus.busy         = busy_q;
   assign bus.line_done    = line_done_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.trig_err     = trig_err_q;
   assign bus.line_idx     = line_q;
   assign bus.dbf_lut_we   = lut_we;
   assign bus.dbf_lut_addr = lut_addr_q;

endmodule

// File: tb/tb_dbf_line_seq.sv
// tb_dbf_line_seq: bench for dbf_line_seq; line-timeline reference model compared
// every cycle, plus literal expectations for the directed line scenarios.
module tb_dbf_line_seq;
   import dbf_line_seq_pkg::*;

   localparam int OW = 7 + LINE_WD + ADDR_WD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dbf_line_seq_if bus ();

   dbf_line_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     n_chk = 0;
   int     n_err = 0;
   longint cyc   = 0;
   bit     chk_on = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] obs();
      return {bus.tx_en, bus.start, bus.busy, bus.line_done, bus.frame_done,
              bus.trig_err, bus.dbf_lut_we, bus.line_idx, bus.dbf_lut_addr};
   endfunction

   // ---------------- reference model: line as a timeline offset k from trig ----------------
   bit          act = 0, pend = 0, was_busy;
   int          k = 0, L = 0, mtx = 0, mdead = 0, mrx = 0, mline = 0, mlnum = 0, r;
   bit          e_tx, e_st, e_busy, e_ld, e_fd, e_err, e_we;
   int          e_addr = 0;
   logic [OW-1:0] e_vec = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         act = 0; pend = 0; k = 0; mline = 0; e_addr = 0;
         e_vec = '0;
      end else begin
         was_busy = act;
         e_err    = bus.trig && was_busy;
         e_fd     = 0;
         if (act) begin
            k++;
            if (k > L) act = 0;
         end
         if (bus.frame_start) begin
            if (was_busy) pend = 1;
            else mline = 0;
         end
         if (!was_busy && bus.trig) begin
            act   = 1;
            k     = 1;
            mtx   = int'(bus.cfg_tx_len);
            mdead = int'(bus.cfg_dead_len);
            mrx   = int'(bus.cfg_rx_len);
            L     = mtx + mdead + mrx + 1;
            mlnum = mline;
         end
         if (act && k == L) begin
            e_fd = (mline == NUM_LINES - 1);
            if (pend) begin
               mline = 0;
               pend  = 0;
            end else begin
               mline = (mline + 1) % NUM_LINES;
            end
         end
         e_tx   = act && k >= 1 && k <= mtx;
         e_st   = act && k > mtx + mdead && k <= mtx + mdead + mrx;
         e_busy = act;
         e_ld   = act && k == L;
         e_we   = 0;
         if (e_st) begin
            r = k - (mtx + mdead + 1);
            if (r % ZONE_LEN == 0 && r / ZONE_LEN < NUM_ZONES) begin
               e_we   = 1;
               e_addr = mlnum * NUM_ZONES + r / ZONE_LEN;
            end
         end
         e_vec = {e_tx, e_st, e_busy, e_ld, e_fd, e_err, e_we,
                  LINE_WD'(mline), ADDR_WD'(e_addr)};
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) check($sformatf("outputs@cyc%0d", cyc), 64'(obs()), 64'(e_vec));
   end

   // ---------------- directed line driver with observation ----------------
   int tx_first, tx_cnt, st_first, st_cnt, done_off, err_off, fd_off;
   int we_off[$];
   int we_addr[$];

   // fs_at: -1 none, 0 together with trig, >0 at that offset. trig_at: 0 none.
   task automatic run_line(input int tx, input int dead, input int rx,
                           input int trig_at, input int fs_at);
      tx_first = -1; tx_cnt = 0; st_first = -1; st_cnt = 0;
      done_off = -1; err_off = -1; fd_off = -1;
      we_off.delete();
      we_addr.delete();
      bus.trig         = 1'b1;
      bus.frame_start  = (fs_at == 0);
      bus.cfg_tx_len   = LEN_WD'(tx);
      bus.cfg_dead_len = LEN_WD'(dead);
      bus.cfg_rx_len   = RX_WD'(rx);
      for (int off = 1; off <= 4000 && done_off < 0; off++) begin
         @(negedge clk);
         bus.trig         = (off == trig_at);
         bus.frame_start  = (off == fs_at);
         // Scramble config after acceptance; the line in flight must ignore it.
         bus.cfg_tx_len   = LEN_WD'($urandom);
         bus.cfg_dead_len = LEN_WD'($urandom);
         bus.cfg_rx_len   = RX_WD'($urandom);
         if (bus.tx_en) begin
            if (tx_cnt == 0) tx_first = off;
            tx_cnt++;
         end
         if (bus.start) begin
            if (st_cnt == 0) st_first = off;
            st_cnt++;
         end
         if (bus.dbf_lut_we) begin
            we_off.push_back(off);
            we_addr.push_back(int'(bus.dbf_lut_addr));
         end
         if (bus.trig_err && err_off < 0) err_off = off;
         if (bus.frame_done) fd_off = off;
         if (bus.line_done) done_off = off;
      end
      check("line_done_seen", 64'(done_off >= 0), 64'(1));
      bus.trig        = 1'b0;
      bus.frame_start = 1'b0;
      @(negedge clk);
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   int fd_total, fd_line, seq_bad;

   initial begin
      rst              = 1'b1;
      bus.trig         = 1'b0;
      bus.frame_start  = 1'b0;
      bus.cfg_tx_len   = '0;
      bus.cfg_dead_len = '0;
      bus.cfg_rx_len   = '0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      check("reset_state", 64'(obs()), 64'(0));
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Nominal line: tx 4, dead 2, rx 200 on line 0.
      run_line(4, 2, 200, 0, -1);
      check("nom_tx_first", 64'(tx_first), 64'(1));
      check("nom_tx_cnt",   64'(tx_cnt),   64'(4));
      check("nom_st_first", 64'(st_first), 64'(7));
      check("nom_st_cnt",   64'(st_cnt),   64'(200));
      check("nom_we_cnt",   64'(we_off.size()), 64'(4));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("nom_we_off%0d", i),  64'(q_at(we_off, i)),  64'(7 + 64 * i));
         check($sformatf("nom_we_addr%0d", i), 64'(q_at(we_addr, i)), 64'(i));
      end
      check("nom_done_off", 64'(done_off), 64'(207));
      check("nom_line_idx", 64'(bus.line_idx), 64'(1));

      // All-zero tx/dead on line 1.
      run_line(0, 0, 5, 0, -1);
      check("zero_tx_cnt",   64'(tx_cnt),   64'(0));
      check("zero_st_first", 64'(st_first), 64'(1));
      check("zero_st_cnt",   64'(st_cnt),   64'(5));
      check("zero_we_cnt",   64'(we_off.size()), 64'(1));
      check("zero_we_addr",  64'(q_at(we_addr, 0)), 64'(16));
      check("zero_done_off", 64'(done_off), 64'(6));

      // Zone saturation on line 2.
      run_line(3, 1, 1200, 0, -1);
      check("sat_st_cnt",   64'(st_cnt), 64'(1200));
      check("sat_we_cnt",   64'(we_off.size()), 64'(16));
      check("sat_last_addr", 64'(q_at(we_addr, 15)), 64'(2 * 16 + 15));
      check("sat_last_off",  64'(q_at(we_off, 15)),  64'(5 + 960));

      // trig during RX on line 3: flagged, timing unchanged.
      run_line(2, 1, 20, 10, -1);
      check("err_off",      64'(err_off),  64'(11));
      check("err_done_off", 64'(done_off), 64'(24));
      check("err_st_cnt",   64'(st_cnt),   64'(20));

      // Line wrap over a whole frame.
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      check("fs_idle_line", 64'(bus.line_idx), 64'(0));
      fd_total = 0; fd_line = -1; seq_bad = 0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (int'(bus.line_idx) != i) seq_bad++;
         run_line(1, 0, 1, 0, -1);
         if (fd_off >= 0) begin
            fd_total++;
            if (fd_off == done_off) fd_line = i;
         end
      end
      check("wrap_seq_bad",  64'(seq_bad),  64'(0));
      check("wrap_fd_total", 64'(fd_total), 64'(1));
      check("wrap_fd_line",  64'(fd_line),  64'(NUM_LINES - 1));
      check("wrap_line_idx", 64'(bus.line_idx), 64'(0));

      // frame_start mid-line 5.
      for (int i = 0; i < 5; i++) run_line(1, 1, 2, 0, -1);
      check("pre_fs_line", 64'(bus.line_idx), 64'(5));
      run_line(2, 1, 30, 0, 12);
      check("fs_mid_done_off", 64'(done_off), 64'(34));
      check("fs_mid_no_fd",    64'(fd_off + 1), 64'(0));
      check("fs_mid_line",     64'(bus.line_idx), 64'(0));

      // Simultaneous trig + frame_start in IDLE on line 1.
      run_line(1, 0, 3, 0, -1);
      run_line(1, 0, 3, 0, 0);
      check("fs_trig_addr", 64'(q_at(we_addr, 0)), 64'(0));
      check("fs_trig_line", 64'(bus.line_idx), 64'(1));

      // Reset mid-TX.
      bus.trig = 1'b1; bus.cfg_tx_len = 8'd10; bus.cfg_dead_len = 8'd0; bus.cfg_rx_len = 14'd5;
      @(negedge clk);
      bus.trig = 1'b0;
      @(negedge clk);
      check("rst_tx_before", 64'(bus.tx_en), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("rst_tx_after",   64'(bus.tx_en), 64'(0));
      check("rst_busy_after", 64'(bus.busy),  64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_line_idx", 64'(bus.line_idx), 64'(0));

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         bus.trig         = ($urandom_range(0, 5) == 0);
         bus.frame_start  = ($urandom_range(0, 59) == 0);
         rst              = ($urandom_range(0, 1999) == 0);
         bus.cfg_tx_len   = LEN_WD'($urandom_range(0, 6));
         bus.cfg_dead_len = LEN_WD'($urandom_range(0, 3));
         bus.cfg_rx_len   = ($urandom_range(0, 19) == 0) ? RX_WD'($urandom_range(900, 1100))
                                                         : RX_WD'($urandom_range(0, 150));
         @(negedge clk);
      end
      rst = 1'b0;
      bus.trig = 1'b0;
      bus.frame_start = 1'b0;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dbf_line_seq.md
Name: dbf_line_seq

Overview:
- Per-line receive sequencer for the DBF channel bank: on each transmit trigger it drives tx_en, waits a dead time, then opens the receive window (start).
- During the window it steps the coarse/fine delay LUT address through focal zones and issues one-cycle LUT read strobes.
- One instance fans out to all dbf_chN blocks (shared tx_en, start, dbf_lut_addr, dbf_lut_we).
- It also tracks line index within a frame.

Parameters:
- ADDR_WD, 10, LUT address width; must satisfy 2^ADDR_WD >= NUM_LINES*NUM_ZONES.
- NUM_LINES, 64, lines per frame (power of 2).
- NUM_ZONES, 16, focal zones per line (power of 2).
- ZONE_LEN, 64, receive cycles per focal zone.
- LEN_WD, 8, width of tx/dead length config.
- RX_WD, 14, width of receive length config.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- trig  in  1  fire one line (single-cycle pulse)
- frame_start  in  1  restart line count at 0
- cfg_tx_len  in  LEN_WD  tx_en duration, cycles
- cfg_dead_len  in  LEN_WD  gap between tx_en fall and start rise
- cfg_rx_len  in  RX_WD  receive window length, cycles
- tx_en  out  1  transmit active (channels ignore input samples)
- start  out  1  receive window active
- dbf_lut_addr  out  ADDR_WD  delay LUT address = {line_idx, zone_idx}, zero-extended
- dbf_lut_we  out  1  LUT read strobe, one cycle per zone
- line_idx  out  log2(NUM_LINES)  current line
- busy  out  1  high in any state but IDLE
- line_done  out  1  one-cycle pulse at end of line
- frame_done  out  1  one-cycle pulse with last line_done of frame
- trig_err  out  1  one-cycle pulse: trig received while busy

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, pending frame flag 0. Reset mid-line aborts immediately; tx_en and start are low on the next cycle.
- States are IDLE, TX, DEAD, RX, DONE. One down-counter is loaded on each state entry.
- cfg_* is sampled only in the cycle trig is accepted. Later changes do not affect the line in flight.
- IDLE:
  - trig in cycle N: enter TX; tx_en is high from cycle N+1 for exactly cfg_tx_len cycles.
  - If cfg_tx_len==0, skip to DEAD. A zero dead length skips to RX. A zero rx length skips to DONE. Skips take no extra cycles.
- DEAD: tx_en=0, start=0 for cfg_dead_len cycles.
- RX:
  - start=1 for exactly cfg_rx_len cycles.
  - zone_idx=0 on entry, and dbf_lut_we pulses in the first RX cycle.
  - Every ZONE_LEN cycles, zone_idx increments and dbf_lut_we pulses again.
  - zone_idx saturates at NUM_ZONES-1; no further strobes after saturation.
  - dbf_lut_addr changes in the same cycle as its strobe and holds otherwise.
- DONE (1 cycle):
  - line_done=1, start=0.
  - line_idx increments. At NUM_LINES-1 it wraps to 0 and frame_done=1 in the same cycle.
  - Next state is IDLE.
- tx_en and start are never high together; there is at least 0 cycles gap (dead len 0 gives back-to-back).
- trig while busy: ignored, trig_err=1 next cycle, line unaffected.
- frame_start in IDLE: line_idx=0 next cycle. Simultaneous trig and frame_start in IDLE: the line fires with line_idx 0.
- frame_start while busy: sets the pending flag. It is applied in DONE in place of increment (line_idx=0, no frame_done unless the wrap coincides).
- Outputs are registered. Total line length is 1+tx+dead+rx cycles from trig to line_done (DONE cycle included).

Decomposition:
- Shared package/header (param.h): ADDR_WD, NUM_LINES, NUM_ZONES, ZONE_LEN, the state encoding localparams, and a log2 constant function.
- One natural sub-module, dbf_zone_ctr: zone counter/strobe generator (load, enable, ZONE_LEN cycle count, saturating zone_idx, we pulse).

Test Plan:
- tx=4, dead=2, rx=200, ZONE_LEN=64, trig at cycle 10:
  - tx_en high on cycles 11-14 and start high on 17-216.
  - dbf_lut_we pulses on 17, 81, 145, 209 with addr 0,1,2,3.
  - line_done on 217.
- Zero lengths: tx=0, dead=0, rx=5 -> start high from trig+1 for 5 cycles, one we pulse, no tx_en.
- Zone saturation: rx=1200, NUM_ZONES=16 -> 16 strobes, final addr {line,15}, no strobe after cycle 960 of RX.
- Line wrap: 64 trigs -> line_idx 0..63, frame_done coincides with the 64th line_done, line_idx returns to 0.
- Error/collision cases:
  - trig mid-RX -> trig_err pulse, timing unchanged.
  - frame_start mid-line 5 -> line_idx 0 after DONE.
  - rst asserted mid-TX -> tx_en 0 next cycle, state IDLE.
